// File: rtl/seq_signal_mixer.sv
// seq_signal_mixer: sequential per-channel gain/accumulate mixer with normalise and saturate
module seq_signal_mixer #(
  parameter int NUM_CH     = 12,
  parameter int SAMPLE_W   = 8,
  parameter int GAIN_W     = 4,
  parameter int GAIN_FRAC  = 3,
  parameter int NORM_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
  input  logic [NUM_CH*GAIN_W-1:0]   gain_in,
  input  logic [NUM_CH-1:0]          sample_enable,
  input  logic                       norm_en,
  output logic                       busy,
  output logic                       out_valid,
  output logic [SAMPLE_W-1:0]        sample_out,
  output logic                       clip,
  output logic                       overrun
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PW    = SAMPLE_W + GAIN_W;
  localparam int ACC_W = PW + $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t                     state_q, state_d;
  logic [NUM_CH*SAMPLE_W-1:0] smp_q, smp_d;
  logic [NUM_CH*GAIN_W-1:0]   gain_q, gain_d;
  logic [NUM_CH-1:0]          en_q, en_d;
  logic                       norm_q, norm_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic                       out_valid_q, out_valid_d;
  logic [SAMPLE_W-1:0]        sample_out_q, sample_out_d;
  logic                       clip_q, clip_d;
  logic                       overrun_q, overrun_d;
  logic                       start_prev_q, start_prev_d;
  logic [SAMPLE_W-1:0]        smp;
  logic [GAIN_W-1:0]          g;
  logic [PW-1:0]              prod;
  logic [ACC_W-1:0]           term, r;
  logic                       sat;
  always_comb begin
    smp  = smp_q[ch_q*SAMPLE_W +: SAMPLE_W];
    g    = gain_q[ch_q*GAIN_W +: GAIN_W];
    prod = PW'(smp) * PW'(g);
    term = en_q[ch_q] ? ACC_W'(prod >> GAIN_FRAC) : '0;
    r    = norm_q ? acc_q >> NORM_SHIFT : acc_q;
    sat  = r >= ACC_W'({SAMPLE_W{1'b1}});
    state_d      = state_q;
    smp_d        = smp_q;
    gain_d       = gain_q;
    en_d         = en_q;
    norm_d       = norm_q;
    acc_d        = acc_q;
    ch_d         = ch_q;
    out_valid_d  = 1'b0;
    sample_out_d = sample_out_q;
    clip_d       = clip_q;
    start_prev_d = start;
    // a start held high since its accepted capture is a repeat request, not an overrun
    overrun_d    = overrun_q | (start & ~start_prev_q & (state_q != IDLE));
    case (state_q)
      IDLE: if (start) begin
        smp_d   = sample_in;
        gain_d  = gain_in;
        en_d    = sample_enable;
        norm_d  = norm_en;
        acc_d   = '0;
        ch_d    = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_d   = acc_q + term;
        ch_d    = ch_q + CH_W'(1);
        state_d = (ch_q == CH_W'(NUM_CH - 1)) ? DONE : ACCUM;
      end
      DONE: begin
        sample_out_d = sat ? {SAMPLE_W{1'b1}} : r[SAMPLE_W-1:0];
        clip_d       = sat;
        out_valid_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      smp_q        <= '0;
      gain_q       <= '0;
      en_q         <= '0;
      norm_q       <= 1'b0;
      acc_q        <= '0;
      ch_q         <= '0;
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
      clip_q       <= 1'b0;
      overrun_q    <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      smp_q        <= smp_d;
      gain_q       <= gain_d;
      en_q         <= en_d;
      norm_q       <= norm_d;
      acc_q        <= acc_d;
      ch_q         <= ch_d;
      out_valid_q  <= out_valid_d;
      sample_out_q <= sample_out_d;
      clip_q       <= clip_d;
      overrun_q    <= overrun_d;
      start_prev_q <= start_prev_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign out_valid  = out_valid_q;
  assign sample_out = sample_out_q;
  assign clip       = clip_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_seq_signal_mixer.sv
// tb_seq_signal_mixer: vector table, random model comparison and handshake sequences
module tb_seq_signal_mixer;
  logic        clk = 1'b0;
  logic        rst, start, norm_en;
  logic [95:0] sample_in;
  logic [47:0] gain_in;
  logic [11:0] sample_enable;
  logic        busy, out_valid, clip, overrun;
  logic [7:0]  sample_out;
  int checks = 0;
  int errors = 0;

  seq_signal_mixer dut (
    .clk(clk), .rst(rst), .start(start), .sample_in(sample_in), .gain_in(gain_in),
    .sample_enable(sample_enable), .norm_en(norm_en), .busy(busy), .out_valid(out_valid),
    .sample_out(sample_out), .clip(clip), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] s;
    logic [47:0] g;
    logic [11:0] en;
    logic        nrm;
    int          exp_out;
    int          exp_clip;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [95:0] s3(input int a, input int b, input int c);
    logic [95:0] v = '0;
    v[7:0] = 8'(a); v[15:8] = 8'(b); v[23:16] = 8'(c);
    return v;
  endfunction

  function automatic logic [47:0] g3(input int a, input int b, input int c);
    logic [47:0] v = {12{4'd8}};
    v[3:0] = 4'(a); v[7:4] = 4'(b); v[11:8] = 4'(c);
    return v;
  endfunction

  // reference: straight sum of scaled enabled channels, then shift and clamp
  function automatic int model(input logic [95:0] s, input logic [47:0] g, input logic [11:0] en,
                               input logic nrm, output int c);
    int sum = 0;
    for (int k = 0; k < 12; k++)
      if (en[k]) sum += (int'(s[k*8 +: 8]) * int'(g[k*4 +: 4])) / 8;
    if (nrm) sum = sum / 4;
    c = (sum >= 255) ? 1 : 0;
    return (sum >= 255) ? 255 : sum;
  endfunction

  task automatic do_mix(input logic [95:0] s, input logic [47:0] g, input logic [11:0] en,
                        input logic nrm, output int lat);
    @(negedge clk);
    sample_in = s; gain_in = g; sample_enable = en; norm_en = nrm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sample_in = {$urandom(), $urandom(), $urandom()};
    gain_in = 48'({$urandom(), $urandom()});
    sample_enable = 12'($urandom());
    norm_en = 1'($urandom());
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  vec_t vt[9];

  initial begin
    int lat, e, c, n, val, last;
    vt[0] = '{s3(10, 20, 30), {12{4'd8}}, 12'h007, 1'b0, 60, 0};
    vt[1] = '{{12{8'd200}}, {12{4'd8}}, 12'hfff, 1'b0, 255, 1};
    vt[2] = '{{12{8'd200}}, {12{4'd8}}, 12'hfff, 1'b1, 255, 1};
    vt[3] = '{s3(50, 50, 0), {12{4'd8}}, 12'h003, 1'b1, 25, 0};
    vt[4] = '{s3(100, 100, 255), g3(4, 15, 8), 12'h003, 1'b0, 237, 0};
    vt[5] = '{s3(255, 0, 0), {12{4'd8}}, 12'h001, 1'b0, 255, 1};
    vt[6] = '{{12{8'd77}}, {12{4'd8}}, 12'h000, 1'b0, 0, 0};
    vt[7] = '{s3(200, 0, 0), g3(0, 8, 8), 12'h001, 1'b0, 0, 0};
    vt[8] = '{s3(254, 0, 0), {12{4'd8}}, 12'h001, 1'b0, 254, 0};

    rst = 1'b1; start = 1'b0; norm_en = 1'b0;
    sample_in = '0; gain_in = '0; sample_enable = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset sample_out", sample_out, 0);
    chk("reset clip", clip, 0);
    chk("reset overrun", overrun, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      do_mix(vt[i].s, vt[i].g, vt[i].en, vt[i].nrm, lat);
      chk($sformatf("vec%0d latency", i), lat, 13);
      chk($sformatf("vec%0d sample_out", i), sample_out, vt[i].exp_out);
      chk($sformatf("vec%0d clip", i), clip, vt[i].exp_clip);
      chk($sformatf("vec%0d busy", i), busy, 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [95:0] s;
      logic [47:0] g;
      logic [11:0] en;
      logic nrm;
      s = {$urandom(), $urandom(), $urandom()};
      g = 48'({$urandom(), $urandom()});
      en = 12'($urandom()) & 12'($urandom());
      nrm = 1'($urandom());
      e = model(s, g, en, nrm, c);
      do_mix(s, g, en, nrm, lat);
      chk($sformatf("rnd%0d latency", i), lat, 13);
      chk($sformatf("rnd%0d sample_out", i), sample_out, e);
      chk($sformatf("rnd%0d clip", i), clip, c);
    end
    chk("overrun after clean mixes", overrun, 0);

    // second start at cycle 5 is an overrun; input change at cycle 1 must not leak in
    @(negedge clk);
    sample_in = s3(10, 20, 30); gain_in = {12{4'd8}}; sample_enable = 12'h007; norm_en = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sample_in = {12{8'd99}}; sample_enable = 12'hfff;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("overrun set", overrun, 1);
    n = 0; val = -1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin n++; val = sample_out; end
    end
    chk("handshake pulses", n, 1);
    chk("handshake snapshot", val, 60);
    chk("overrun sticky", overrun, 1);

    // reset partway through accumulation
    do_mix(s3(10, 20, 30), {12{4'd8}}, 12'h007, 1'b0, lat);
    @(negedge clk);
    sample_in = {12{8'd40}}; sample_enable = 12'hfff; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("midreset busy", busy, 0);
    chk("midreset out_valid", out_valid, 0);
    chk("midreset sample_out", sample_out, 0);
    chk("midreset clip", clip, 0);
    chk("midreset overrun", overrun, 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("midreset no pulse", n, 0);

    // start held high: repeated mixes every 14 cycles, all channels disabled
    @(negedge clk);
    sample_in = {12{8'd200}}; gain_in = {12{4'd8}}; sample_enable = '0; norm_en = 1'b0;
    start = 1'b1;
    n = 0; last = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 39) start = 1'b0;
      if (out_valid) begin
        if (last >= 0) chk($sformatf("b2b spacing%0d", n), cyc - last, 14);
        chk($sformatf("b2b sample_out%0d", n), sample_out, 0);
        chk($sformatf("b2b clip%0d", n), clip, 0);
        last = cyc;
        n++;
      end
    end
    chk("b2b pulses", n, 3);
    chk("b2b overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
